// File: rtl/uart_pkg.sv
// Shared UART definitions: TX sequencing states, parity mode encodings and a
// frame-length helper used by both the transmit and receive sides.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    // Line bits per frame: start + data + optional parity + stop bits.
    function automatic int frame_len(input int dataBits, input int parityMode, input int stopBits);
        return 1 + dataBits + ((parityMode != PAR_NONE) ? 1 : 0) + stopBits;
    endfunction

endpackage

// File: rtl/uart_tx_shreg.sv
// Load/shift-right register holding the data word in flight; the LSB is the
// next data bit for the line. Load wins over shift.
module uart_tx_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_lsb
);

    logic [WIDTH-1:0] r_sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr <= '0;
        end else if (i_load) begin
            r_sr <= i_data;
        end else if (i_shift) begin
            r_sr <= {1'b0, r_sr[WIDTH-1:1]};
        end
    end

    assign o_lsb = r_sr[0];

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: accepts a word on a valid/ready handshake and shifts
// out start, data (LSB first), optional parity and stop bits, one per bit_tick.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 bit_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 txd,
    output logic                 busy,
    output logic                 done
);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : gBadDataBits
        $fatal(1, "uart_tx_framer: DATA_BITS must be 5..9");
    end
    if (PARITY_MODE < PAR_NONE || PARITY_MODE > PAR_EVEN) begin : gBadParityMode
        $fatal(1, "uart_tx_framer: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : gBadStopBits
        $fatal(1, "uart_tx_framer: STOP_BITS must be 1 or 2");
    end

    localparam int               CNT_W     = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    tx_state_t        r_state;
    logic             r_txd;
    logic             r_parity;
    logic             r_done;
    logic             r_stopCnt;
    logic [CNT_W-1:0] r_bitCnt;

    tx_state_t        w_stateNext;
    logic             w_txdNext;
    logic             w_parityNext;
    logic             w_doneNext;
    logic             w_stopCntNext;
    logic [CNT_W-1:0] w_bitCntNext;
    logic             w_load;
    logic             w_shift;
    logic             w_lsb;
    logic             w_dataParity;

    // Parity is fixed at accept time so later tx_data changes cannot leak in.
    assign w_dataParity = (PARITY_MODE == PAR_ODD) ? ~(^tx_data) : (^tx_data);

    uart_tx_shreg #(
        .WIDTH (DATA_BITS)
    ) u_shreg (
        .clk     (clk),
        .rst_n   (reset),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_data  (tx_data),
        .o_lsb   (w_lsb)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_txd     <= 1'b1;
            r_parity  <= 1'b0;
            r_done    <= 1'b0;
            r_stopCnt <= 1'b0;
            r_bitCnt  <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_txd     <= w_txdNext;
            r_parity  <= w_parityNext;
            r_done    <= w_doneNext;
            r_stopCnt <= w_stopCntNext;
            r_bitCnt  <= w_bitCntNext;
        end
    end

    // IDLE deliberately ignores bit_tick, so a tick coincident with accept
    // leaves the framer waiting in ARMED for the next full bit period.
    always_comb begin
        w_stateNext   = r_state;
        w_txdNext     = r_txd;
        w_parityNext  = r_parity;
        w_doneNext    = 1'b0;
        w_stopCntNext = r_stopCnt;
        w_bitCntNext  = r_bitCnt;
        w_load        = 1'b0;
        w_shift       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (tx_valid) begin
                    w_load       = 1'b1;
                    w_parityNext = w_dataParity;
                    w_stateNext  = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (bit_tick) begin
                    w_txdNext   = 1'b0;
                    w_stateNext = ST_START;
                end
            end
            ST_START: begin
                if (bit_tick) begin
                    w_txdNext    = w_lsb;
                    w_shift      = 1'b1;
                    w_bitCntNext = '0;
                    w_stateNext  = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    if (r_bitCnt == LAST_BIT) begin
                        if (PARITY_MODE != PAR_NONE) begin
                            w_txdNext   = r_parity;
                            w_stateNext = ST_PARITY;
                        end else begin
                            w_txdNext     = 1'b1;
                            w_stopCntNext = 1'b0;
                            w_stateNext   = ST_STOP;
                        end
                    end else begin
                        w_txdNext    = w_lsb;
                        w_shift      = 1'b1;
                        w_bitCntNext = r_bitCnt + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_tick) begin
                    w_txdNext     = 1'b1;
                    w_stopCntNext = 1'b0;
                    w_stateNext   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_tick) begin
                    if (r_stopCnt == LAST_STOP) begin
                        w_doneNext  = 1'b1;
                        w_stateNext = ST_IDLE;
                    end else begin
                        w_stopCntNext = 1'b1;
                    end
                end
            end
            default: begin
                w_txdNext   = 1'b1;
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    assign tx_ready = (r_state == ST_IDLE);
    assign busy     = (r_state != ST_IDLE);
    assign txd      = r_txd;
    assign done     = r_done;

endmodule
